// File: rtl/pipe_register_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_register_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  // Bits needed to hold an occupancy of 0..2*depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_register_if.sv
// Streaming bus of the elastic pipeline register: upstream side, downstream side, flush, occupancy.
// Latency: n/a (wires only).
// Backpressure: carried by o_ready toward the producer and i_ready from the consumer.
interface pipe_register_if import pipe_register_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = count_width(DEF_DEPTH)
) ();

  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic [CW-1:0]    o_count;

  // Producer/consumer view: drives the i_* side, observes the o_* side.
  modport master (
    output i_flush, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );

  // Pipeline view: receives the i_* side, drives the o_* side.
  modport slave (
    input  i_flush, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count
  );

endinterface

// File: rtl/pipe_reg_slice.sv
// One main+skid register slice; registers data, valid and ready paths.
// Latency: a word accepted at an edge is on o_valid/o_data right after that edge.
// Backpressure: absorbs one extra word in the skid when stalled; o_ready = !skid_v.
module pipe_reg_slice import pipe_register_pkg::*; #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_main_v;
  logic [WIDTH-1:0] r_main_d;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_skid_d;

  logic w_in_fire;
  logic w_out_fire;

  // Ready depends only on the skid flop, so downstream ready never reaches upstream combinationally.
  assign o_ready    = !r_skid_v;
  assign o_valid    = r_main_v;
  assign o_data     = r_main_d;
  assign w_in_fire  = i_valid && !r_skid_v;
  assign w_out_fire = r_main_v && i_ready;

  // Main/skid update: drain skid first, otherwise refill main, otherwise park the new word in skid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_v <= 1'b0;
      r_main_d <= RESET_VAL;
      r_skid_v <= 1'b0;
      r_skid_d <= RESET_VAL;
    end else if (i_flush) begin
      // Flags only: stale data is harmless once the valids are low.
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      if (w_out_fire) begin
        r_main_v <= 1'b1;
        r_main_d <= r_skid_d;
        r_skid_v <= 1'b0;
      end
    end else if (!r_main_v || w_out_fire) begin
      r_main_v <= w_in_fire;
      if (w_in_fire) begin
        r_main_d <= i_data;
      end
    end else if (w_in_fire) begin
      r_skid_v <= 1'b1;
      r_skid_d <= i_data;
    end
  end

endmodule

// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH chained main+skid slices with flush and an occupancy count.
// Latency: DEPTH register delays (word accepted at edge N is visible after edge N+DEPTH-1).
// Backpressure: holds up to 2*DEPTH words with i_ready low; o_ready comes straight from a flop.
module pipe_register import pipe_register_pkg::*; #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pipe_register_if.slave bus
);

  localparam int CW = count_width(DEPTH);

  // Stage k's input is w_*[k]; its output is w_*[k+1].
  logic             w_vld [DEPTH+1];
  logic             w_rdy [DEPTH+1];
  logic [WIDTH-1:0] w_dat [DEPTH+1];

  logic          w_in_fire;
  logic          w_out_fire;
  logic [CW-1:0] r_count;

  assign w_vld[0]     = bus.i_valid;
  assign w_dat[0]     = bus.i_data;
  assign w_rdy[DEPTH] = bus.i_ready;

  assign bus.o_ready = w_rdy[0];
  assign bus.o_valid = w_vld[DEPTH];
  assign bus.o_data  = w_dat[DEPTH];
  assign bus.o_count = r_count;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    pipe_reg_slice #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slice (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (bus.i_flush),
      .i_valid (w_vld[k]),
      .o_ready (w_rdy[k]),
      .i_data  (w_dat[k]),
      .o_valid (w_vld[k+1]),
      .i_ready (w_rdy[k+1]),
      .o_data  (w_dat[k+1])
    );
  end

  assign w_in_fire  = bus.i_valid && w_rdy[0];
  assign w_out_fire = w_vld[DEPTH] && bus.i_ready;

  // Occupancy tracks block-level accepts minus deliveries; flush empties everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (bus.i_flush) begin
      r_count <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register: DEPTH=2/WIDTH=32 and DEPTH=1/WIDTH=8 instances.
// Latency: n/a.
// Backpressure: exercised via i_ready stalls and random handshakes.
module tb_pipe_register;
  import pipe_register_pkg::*;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];

  pipe_register_if #(.WIDTH(32), .CW(count_width(2))) bus ();
  pipe_register_if #(.WIDTH(8),  .CW(count_width(1))) bus1 ();

  pipe_register #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  pipe_register #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen after a negedge equals edges elapsed so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle();
    bus.i_flush  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus.i_ready  = 1'b0;
    bus1.i_flush = 1'b0;
    bus1.i_valid = 1'b0;
    bus1.i_data  = '0;
    bus1.i_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.o_valid); end
    n_tests++; if (bus.o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", bus.o_data); end
    n_tests++; if (bus.o_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", bus.o_count); end
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.o_ready); end
    n_tests++; if (bus1.o_data !== 8'h5A) begin n_fail++; $display("FAIL reset_val_d1: got %h required 5a", bus1.o_data); end
    n_tests++; if (bus1.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_d1: got %b required 0", bus1.o_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    // Fill three words under stall, then reset asynchronously between edges.
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h100 + 32'(k);
      step();
    end
    idle();
    #1;
    n_tests++; if (bus.o_count !== 3'd3) begin n_fail++; $display("FAIL midrst_precount: got %0d required 3", bus.o_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", bus.o_valid); end
    n_tests++; if (bus.o_data !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h required 0", bus.o_data); end
    n_tests++; if (bus.o_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d required 0", bus.o_count); end
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", bus.o_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    e.d = 0; e.c = 0;
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    exp_t e;
    int   i = 0, got = 0, t = 0;
    words = '{32'h12345678, 32'hABCDEF00, 32'hDEADBEEF};
    bus.i_ready = 1'b1;
    while (got < 3 && t < 20) begin
      bus.i_valid = (i < 3);
      bus.i_data  = words[i % 3];
      #1;
      if (bus.o_valid && bus.i_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: got %h required no output", bus.o_data);
        end else begin
          e = sb.pop_front();
          if (bus.o_data !== e.d || cyc != e.c + 1) begin
            n_fail++; $display("FAIL stream_word: got %h at edge %0d required %h at edge %0d", bus.o_data, cyc, e.d, e.c + 1);
          end
        end
        got++;
      end
      if (bus.i_valid && bus.o_ready) begin
        e.d = words[i % 3]; e.c = cyc + 1; sb.push_back(e); i++;
      end
      step();
      t++;
    end
    n_tests++; if (got != 3) begin n_fail++; $display("FAIL stream_timeout: got %0d words required 3", got); end
    idle();
    sb.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   i = 0, got = 0, t = 0, last = -1;
    bus.i_ready = 1'b0;
    repeat (8) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'(i);
      #1;
      if (bus.o_ready) begin
        e.d = 32'(i); e.c = cyc + 1; sb.push_back(e); i++;
      end
      step();
    end
    #1;
    n_tests++; if (i != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d required 4", i); end
    n_tests++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b required 0", bus.o_ready); end
    n_tests++; if (bus.o_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d required 4", bus.o_count); end
    bus.i_ready = 1'b1;
    while (got < 6 && t < 30) begin
      bus.i_valid = (i < 6);
      bus.i_data  = 32'(i);
      #1;
      if (bus.o_valid && bus.i_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: got %h required no output", bus.o_data);
        end else begin
          e = sb.pop_front();
          if (bus.o_data !== e.d) begin
            n_fail++; $display("FAIL bp_order: got %h required %h", bus.o_data, e.d);
          end
        end
        n_tests++;
        if (last >= 0 && cyc != last + 1) begin
          n_fail++; $display("FAIL bp_gap: output at edge %0d required edge %0d", cyc, last + 1);
        end
        last = cyc;
        got++;
      end
      if (bus.i_valid && bus.o_ready) begin
        e.d = 32'(i); e.c = cyc + 1; sb.push_back(e); i++;
      end
      step();
      t++;
    end
    n_tests++; if (got != 6) begin n_fail++; $display("FAIL bp_timeout: got %0d words required 6", got); end
    idle();
    sb.delete();
  endtask

  task automatic test_flush();
    exp_t e;
    int   got = 0;
    logic sent = 1'b0;
    bus.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 32'h11 * 32'(k + 1);
      step();
    end
    bus.i_valid = 1'b0;
    #1;
    n_tests++; if (bus.o_count !== 3'd3) begin n_fail++; $display("FAIL flush_precount: got %0d required 3", bus.o_count); end
    bus.i_valid = 1'b1;
    bus.i_data  = 32'hCAFEBABE;
    bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b required 0", bus.o_valid); end
    n_tests++; if (bus.o_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d required 0", bus.o_count); end
    n_tests++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b required 1", bus.o_ready); end
    sb.delete();
    bus.i_ready = 1'b1;
    bus.i_data  = 32'hFEEDFACE;
    repeat (8) begin
      bus.i_valid = !sent;
      #1;
      if (bus.o_valid && bus.i_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL flush_extra: got %h required no output", bus.o_data);
        end else begin
          e = sb.pop_front();
          if (bus.o_data !== e.d) begin
            n_fail++; $display("FAIL flush_word: got %h required %h", bus.o_data, e.d);
          end
        end
        got++;
      end
      if (bus.i_valid && bus.o_ready) begin
        e.d = 32'hFEEDFACE; e.c = cyc + 1; sb.push_back(e); sent = 1'b1;
      end
      step();
    end
    n_tests++; if (got != 1) begin n_fail++; $display("FAIL flush_after: got %0d words required 1", got); end
    idle();
    sb.delete();
  endtask

  task automatic test_random();
    exp_t e;
    int   sent = 0, t = 0;
    while ((sent < 1000 || sb.size() != 0) && t < 20000) begin
      bus.i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.i_data  = $urandom;
      bus.i_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (int'(bus.o_count) != sb.size()) begin
        n_fail++; $display("FAIL rand_count: got %0d required %0d at edge %0d", bus.o_count, sb.size(), cyc);
      end
      if (bus.o_valid && bus.i_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got %h required no output", bus.o_data);
        end else begin
          e = sb.pop_front();
          if (bus.o_data !== e.d) begin
            n_fail++; $display("FAIL rand_order: got %h required %h", bus.o_data, e.d);
          end
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        e.d = bus.i_data; e.c = cyc + 1; sb.push_back(e); sent++;
      end
      step();
      t++;
    end
    n_tests++; if (sent != 1000 || sb.size() != 0) begin n_fail++; $display("FAIL rand_timeout: sent %0d left %0d required 1000 and 0", sent, sb.size()); end
    idle();
    sb.delete();
  endtask

  task automatic test_depth1();
    logic [7:0] words [4];
    exp_t e;
    int   i = 0, got = 0, t = 0, acc = 0;
    words = '{8'h01, 8'h80, 8'h7F, 8'hFF};
    bus1.i_ready = 1'b1;
    while (got < 4 && t < 20) begin
      bus1.i_valid = (i < 4);
      bus1.i_data  = words[i % 4];
      #1;
      if (bus1.o_valid && bus1.i_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL d1_extra: got %h required no output", bus1.o_data);
        end else begin
          e = sb.pop_front();
          if ({24'h0, bus1.o_data} !== e.d || cyc != e.c) begin
            n_fail++; $display("FAIL d1_word: got %h at edge %0d required %h at edge %0d", bus1.o_data, cyc, e.d[7:0], e.c);
          end
        end
        got++;
      end
      if (bus1.i_valid && bus1.o_ready) begin
        e.d = {24'h0, words[i % 4]}; e.c = cyc + 1; sb.push_back(e); i++;
      end
      step();
      t++;
    end
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL d1_timeout: got %0d words required 4", got); end
    // Capacity of a single slice under stall.
    bus1.i_ready = 1'b0;
    repeat (4) begin
      bus1.i_valid = 1'b1;
      bus1.i_data  = 8'hC0 + 8'(acc);
      #1;
      if (bus1.o_ready) begin
        e.d = {24'h0, 8'hC0 + 8'(acc)}; e.c = cyc + 1; sb.push_back(e); acc++;
      end
      step();
    end
    bus1.i_valid = 1'b0;
    #1;
    n_tests++; if (acc != 2) begin n_fail++; $display("FAIL d1_capacity: got %0d required 2", acc); end
    n_tests++; if (bus1.o_count !== 2'd2) begin n_fail++; $display("FAIL d1_count: got %0d required 2", bus1.o_count); end
    n_tests++; if (bus1.o_ready !== 1'b0) begin n_fail++; $display("FAIL d1_ready: got %b required 0", bus1.o_ready); end
    bus1.i_ready = 1'b1;
    got = 0; t = 0;
    while (sb.size() != 0 && t < 10) begin
      #1;
      if (bus1.o_valid) begin
        e = sb.pop_front();
        n_tests++;
        if ({24'h0, bus1.o_data} !== e.d) begin
          n_fail++; $display("FAIL d1_drain: got %h required %h", bus1.o_data, e.d[7:0]);
        end
      end
      step();
      t++;
    end
    n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL d1_drain_timeout: %0d words left required 0", sb.size()); end
    idle();
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_depth1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
